// File: rtl/seq_det_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : seq_det_pkg                                                    |
// | Purpose : Shared types and constants for the serial pattern detector:    |
// |           controller state encoding, default widths and the width of     |
// |           the pattern-length field.                                      |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package seq_det_pkg;

  localparam int DEF_PAT_W = 8;
  localparam int DEF_CNT_W = 8;

  // Length field must hold the value PAT_W itself, hence the extra bit.
  function automatic int len_width(input int pat_w);
    return $clog2(pat_w) + 1;
  endfunction

  localparam int DEF_LEN_W = len_width(DEF_PAT_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/seq_det_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : seq_det_if                                                     |
// | Purpose : Configuration, control and serial-data bundle of the pattern   |
// |           detector.                                                      |
// | Ports   : master -> drives cfg_*, start, abort, din_valid, din           |
// |           slave  -> drives din_ready, match, match_cnt, busy, done,      |
// |                     cfg_err (and timeout when SEQ_DET_TIMEOUT_EN)        |
// | Macro   : SEQ_DET_TIMEOUT_EN adds the timeout signal                     |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface seq_det_if
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) ();

  localparam int LEN_W = len_width(PAT_W);

  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_target;
  logic             start;
  logic             abort;
  logic             din_valid;
  logic             din;
  logic             din_ready;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             busy;
  logic             done;
  logic             cfg_err;
`ifdef SEQ_DET_TIMEOUT_EN
  logic             timeout;
`endif

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    output start, abort, din_valid, din,
`ifdef SEQ_DET_TIMEOUT_EN
    input  timeout,
`endif
    input  din_ready, match, match_cnt, busy, done, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    input  start, abort, din_valid, din,
`ifdef SEQ_DET_TIMEOUT_EN
    output timeout,
`endif
    output din_ready, match, match_cnt, busy, done, cfg_err
  );

endinterface
`default_nettype wire

// File: rtl/seq_det_match.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : seq_det_match                                                  |
// | Purpose : Serial shift register, fill counter and pattern comparator.    |
// | Ports   : clk, rst_n      clock / async active-low reset                 |
// |           clr             restart: empty the window                      |
// |           accept          a bit is taken this cycle                      |
// |           din             serial bit                                     |
// |           pattern/len     active pattern and its length                  |
// |           overlap         keep the window full after a match             |
// |           hit             the bit taken this cycle completes a match     |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module seq_det_match
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = len_width(PAT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             accept,
  input  logic             din,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  output logic             hit
);

  logic [PAT_W-1:0] shift_q, shift_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] shift_nxt;
  logic [LEN_W-1:0] fill_nxt;
  logic [PAT_W-1:0] mask;

  always_comb begin
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
    // Comparison is done on the window as it will be after this bit, so
    // the registered match pulse lines up with the accepting edge.
    shift_nxt = {shift_q[PAT_W-2:0], din};
    fill_nxt  = (fill_q >= len) ? len : fill_q + 1'b1;
    hit       = accept && (len != '0) && (fill_nxt == len) &&
                ((shift_nxt & mask) == (pattern & mask));

    shift_d = shift_q;
    fill_d  = fill_q;
    if (clr) begin
      shift_d = '0;
      fill_d  = '0;
    end else if (accept) begin
      shift_d = shift_nxt;
      fill_d  = (hit && !overlap) ? '0 : fill_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      fill_q  <= '0;
    end else begin
      shift_q <= shift_d;
      fill_q  <= fill_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : seq_det_ctrl                                                   |
// | Purpose : Serial pattern detector controller: shadow configuration,      |
// |           IDLE/RUN/DONE sequencing, match pulse and match counter.       |
// | Ports   : clk     clock, rising edge                                     |
// |           rst_n   asynchronous active-low reset                          |
// |           bus     seq_det_if.slave (config, control, serial data, status)|
// | Macro   : SEQ_DET_TIMEOUT_EN enables the RUN inactivity timeout          |
// |           (TO_CYC cycles without a match returns to IDLE)                |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W  = DEF_PAT_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int TO_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_det_if.slave   bus
);

  localparam int LEN_W = len_width(PAT_W);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_DONE = ST_DONE;

  if (PAT_W < 2 || TO_CYC < 1) begin : g_param_check
    $error("seq_det_ctrl: PAT_W must be >= 2 and TO_CYC >= 1");
  end

  logic [1:0]       state_q, state_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cfg_err_q, cfg_err_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;

  logic             idle_or_done;
  logic             len_ok;
  logic             start_ok;
  logic             accept;
  logic             clr;
  logic             hit;

`ifdef SEQ_DET_TIMEOUT_EN
  localparam int TMO_W = $clog2(TO_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    idle_or_done = (state_q != S_RUN);
    len_ok       = (len_q != '0) && (len_q <= LEN_MAX);
    start_ok     = bus.start && idle_or_done && len_ok;
    // Abort wins over a bit arriving in the same cycle, so that bit can
    // never complete a match.
    accept       = bus.din_valid && (state_q == S_RUN) && !bus.abort;
    clr          = start_ok && !bus.abort;

    state_d   = state_q;
    match_d   = 1'b0;
    cnt_d     = cnt_q;
    cfg_err_d = 1'b0;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    tgt_d     = tgt_q;
`ifdef SEQ_DET_TIMEOUT_EN
    tmo_d     = tmo_q;
    timeout_d = 1'b0;
`endif

    if (bus.cfg_we) begin
      if (idle_or_done) begin
        pat_d = bus.cfg_pattern;
        len_d = bus.cfg_len;
        ovl_d = bus.cfg_overlap;
        tgt_d = bus.cfg_target;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    if (bus.start && idle_or_done && !len_ok) begin
      cfg_err_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d = S_RUN;
          cnt_d   = '0;
`ifdef SEQ_DET_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      S_RUN: begin
        if (hit) begin
          match_d = 1'b1;
          cnt_d   = cnt_q + 1'b1;
`ifdef SEQ_DET_TIMEOUT_EN
          tmo_d   = '0;
`endif
          if (tgt_q != '0 && cnt_d == tgt_q) begin
            state_d = S_DONE;
          end
        end
`ifdef SEQ_DET_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TO_CYC - 1)) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides both re-arming and match completion; the counter
    // keeps its value.
    if (bus.abort) begin
      state_d = S_IDLE;
      match_d = 1'b0;
      cnt_d   = cnt_q;
`ifdef SEQ_DET_TIMEOUT_EN
      timeout_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      match_q   <= 1'b0;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      tgt_q     <= '0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= cfg_err_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      tgt_q     <= tgt_d;
    end
  end

`ifdef SEQ_DET_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`endif

  seq_det_match #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_match (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .accept  (accept),
    .din     (bus.din),
    .pattern (pat_q),
    .len     (len_q),
    .overlap (ovl_q),
    .hit     (hit)
  );

  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.busy      = (state_q == S_RUN);
  assign bus.din_ready = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.cfg_err   = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_seq_det_ctrl                                                |
// | Purpose : Directed self-checking bench for seq_det_ctrl.                 |
// | Macro   : SEQ_DET_TIMEOUT_EN also exercises the timeout path (TO_CYC=16) |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_seq_det_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  seq_det_if #(.PAT_W(8), .CNT_W(8)) bus ();

  seq_det_ctrl #(
    .PAT_W  (8),
    .CNT_W  (8),
    .TO_CYC (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic cfg_write(input logic [7:0] pat, input logic [3:0] len,
                           input logic ovl, input logic [7:0] tgt);
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_overlap = ovl;
    bus.cfg_target  = tgt;
    bus.cfg_we      = 1'b1;
    @(negedge clk);
    bus.cfg_we      = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bus.din       = b;
    bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din_valid = 1'b0;
  endtask

  // s[6] is sent first; m[i] is the match output seen after bit s[i].
  task automatic send_stream(input logic [6:0] s, output logic [6:0] m);
    for (int i = 6; i >= 0; i--) begin
      send_bit(s[i]);
      m[i] = bus.match;
    end
  endtask

  logic [6:0] m;
  logic       any_match;
  int         n_cyc;

  initial begin
    bus.cfg_we = 0; bus.cfg_pattern = 0; bus.cfg_len = 0; bus.cfg_overlap = 0;
    bus.cfg_target = 0; bus.start = 0; bus.abort = 0; bus.din_valid = 0; bus.din = 0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(bus.busy), 0);
    check("rst_done",  32'(bus.done), 0);
    check("rst_ready", 32'(bus.din_ready), 0);
    check("rst_match", 32'(bus.match), 0);
    check("rst_err",   32'(bus.cfg_err), 0);
    check("rst_cnt",   32'(bus.match_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Overlapping matches, unlimited target
    cfg_write(8'h0D, 4'd4, 1'b1, 8'd0);
    check("cfg_ok_err", 32'(bus.cfg_err), 0);
    pulse_start();
    check("arm_busy",  32'(bus.busy), 1);
    check("arm_ready", 32'(bus.din_ready), 1);
    send_stream(7'b1101101, m);
    check("ovl1_match", 32'(m), 32'b0001001);
    check("ovl1_cnt",   32'(bus.match_cnt), 2);
    check("ovl1_busy",  32'(bus.busy), 1);
    pulse_abort();
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_cnt_kept", 32'(bus.match_cnt), 2);

    // Non-overlapping
    cfg_write(8'h0D, 4'd4, 1'b0, 8'd0);
    pulse_start();
    check("rearm_cnt", 32'(bus.match_cnt), 0);
    send_stream(7'b1101101, m);
    check("ovl0_match", 32'(m), 32'b0001000);
    check("ovl0_cnt",   32'(bus.match_cnt), 1);
    pulse_abort();

    // Target reached -> DONE
    cfg_write(8'h0D, 4'd4, 1'b1, 8'd2);
    pulse_start();
    send_stream(7'b1101101, m);
    check("tgt_match", 32'(m), 32'b0001001);
    check("tgt_done",  32'(bus.done), 1);
    check("tgt_ready", 32'(bus.din_ready), 0);
    check("tgt_busy",  32'(bus.busy), 0);
    @(negedge clk);
    check("tgt_match_pulse", 32'(bus.match), 0);
    check("tgt_done_hold",   32'(bus.done), 1);
    any_match = 1'b0;
    send_bit(1'b1); any_match |= bus.match;
    send_bit(1'b1); any_match |= bus.match;
    send_bit(1'b0); any_match |= bus.match;
    send_bit(1'b1); any_match |= bus.match;
    check("done_ignores_din", 32'(any_match), 0);
    check("done_cnt_hold",    32'(bus.match_cnt), 2);
    pulse_start();
    check("done_rearm_busy", 32'(bus.busy), 1);
    check("done_rearm_done", 32'(bus.done), 0);
    check("done_rearm_cnt",  32'(bus.match_cnt), 0);
    pulse_abort();

    // Abort on the completing bit
    cfg_write(8'h0D, 4'd4, 1'b1, 8'd0);
    pulse_start();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    bus.abort = 1'b1;
    send_bit(1'b1);
    bus.abort = 1'b0;
    check("abrt_match", 32'(bus.match), 0);
    check("abrt_busy",  32'(bus.busy), 0);
    check("abrt_ready", 32'(bus.din_ready), 0);
    check("abrt_cnt",   32'(bus.match_cnt), 0);
    @(negedge clk);
    check("abrt_match_late", 32'(bus.match), 0);

    // Config write while running is rejected; gaps between bits tolerated
    pulse_start();
    cfg_write(8'hFF, 4'd8, 1'b0, 8'd0);
    check("run_cfg_err", 32'(bus.cfg_err), 1);
    @(negedge clk);
    check("run_cfg_err_pulse", 32'(bus.cfg_err), 0);
    send_bit(1'b1); send_bit(1'b1);
    bus.din = 1'b0;
    repeat (3) @(negedge clk);
    send_bit(1'b0); send_bit(1'b1);
    check("gap_shadow_match", 32'(bus.match), 1);
    check("gap_shadow_cnt",   32'(bus.match_cnt), 1);
    pulse_start();
    check("start_in_run_cnt", 32'(bus.match_cnt), 1);
    pulse_abort();

    // Illegal length on start
    cfg_write(8'h0D, 4'd0, 1'b1, 8'd0);
    check("len0_cfg_err", 32'(bus.cfg_err), 0);
    pulse_start();
    check("len0_err",  32'(bus.cfg_err), 1);
    check("len0_busy", 32'(bus.busy), 0);
    @(negedge clk);
    check("len0_err_pulse", 32'(bus.cfg_err), 0);
    cfg_write(8'h0D, 4'd9, 1'b1, 8'd0);
    pulse_start();
    check("len9_err",  32'(bus.cfg_err), 1);
    check("len9_busy", 32'(bus.busy), 0);

    // Reset mid-run
    cfg_write(8'h0D, 4'd4, 1'b1, 8'd0);
    pulse_start();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    #2 rst_n = 1'b0;
    #1 check("arst_busy", 32'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_bit(1'b1);
    check("arst_no_match", 32'(bus.match), 0);
    check("arst_cnt",      32'(bus.match_cnt), 0);
    pulse_start();
    check("arst_shadow_len", 32'(bus.cfg_err), 1);

`ifdef SEQ_DET_TIMEOUT_EN
    cfg_write(8'h0D, 4'd4, 1'b1, 8'd0);
    pulse_start();
    n_cyc = 0;
    while (n_cyc < 40) begin
      @(negedge clk);
      n_cyc++;
      if (bus.timeout) break;
    end
    check("tmo_cycles", 32'(n_cyc), 16);
    check("tmo_busy",   32'(bus.busy), 0);
    @(negedge clk);
    check("tmo_pulse",  32'(bus.timeout), 0);
`else
    n_cyc = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
